// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with a register file, Y/Z/HI/LO registers and a
// built-in sequencer that runs Y <- Ra; Z <- Y op Rb; Rc/LO <- ZLO; HI <- ZHI.
module bus_datapath_seq #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] rc,
    output logic              ready,
    output logic              done,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q,
    output logic [DATA_W-1:0] bus_q
);

    localparam int SHW = $clog2(DATA_W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [2:0] {IDLE, S_Y, S_Z, S_WB, S_HI} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [REG_AW-1:0]   r_ra;
    logic [REG_AW-1:0]   r_rb;
    logic [REG_AW-1:0]   r_rc;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_y;
    logic [2*DATA_W-1:0] r_z;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;

    // Bus source select, one-hot: {ZHI, ZLO, R[rb], R[ra]}
    logic [3:0]          w_sel;
    logic [DATA_W-1:0]   w_bus;
    logic [2*DATA_W-1:0] w_alu;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_accept;
    logic                w_wb_reg;

    assign w_accept = (r_state == IDLE) && start;
    assign w_wb_reg = (r_state == S_WB) && (r_op != OP_MUL);

    // Next-state and bus source select, derived from state only
    always_comb begin
        w_next = r_state;
        w_sel  = '0;
        case (r_state)
            IDLE: if (start) w_next = S_Y;
            S_Y: begin
                w_sel[0] = 1'b1;
                w_next   = S_Z;
            end
            S_Z: begin
                w_sel[1] = 1'b1;
                w_next   = S_WB;
            end
            S_WB: begin
                w_sel[2] = 1'b1;
                w_next   = (r_op == OP_MUL) ? S_HI : IDLE;
            end
            S_HI: begin
                w_sel[3] = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // AND-OR bus mux; with no source selected the bus reads zero
    always_comb begin
        w_bus = ({DATA_W{w_sel[0]}} & r_regs[r_ra])
              | ({DATA_W{w_sel[1]}} & r_regs[r_rb])
              | ({DATA_W{w_sel[2]}} & r_z[DATA_W-1:0])
              | ({DATA_W{w_sel[3]}} & r_z[2*DATA_W-1:DATA_W]);
    end

    assign w_prod = $signed({{DATA_W{r_y[DATA_W-1]}}, r_y})
                  * $signed({{DATA_W{w_bus[DATA_W-1]}}, w_bus});

    // ALU: Y op bus; only MUL produces a non-zero upper half
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD: w_alu[DATA_W-1:0] = r_y + w_bus;
            OP_SUB: w_alu[DATA_W-1:0] = r_y - w_bus;
            OP_AND: w_alu[DATA_W-1:0] = r_y & w_bus;
            OP_OR:  w_alu[DATA_W-1:0] = r_y | w_bus;
            OP_SHL: w_alu[DATA_W-1:0] = r_y << w_bus[SHW-1:0];
            OP_SHR: w_alu[DATA_W-1:0] = r_y >> w_bus[SHW-1:0];
            OP_MUL: w_alu = w_prod;
            OP_XOR: w_alu[DATA_W-1:0] = r_y ^ w_bus;
            default: w_alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Operation fields captured on accept, frozen while busy
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_op <= '0;
            r_ra <= '0;
            r_rb <= '0;
            r_rc <= '0;
        end else if (w_accept) begin
            r_op <= op;
            r_ra <= ra;
            r_rb <= rb;
            r_rc <= rc;
        end
    end

    // Y, Z, HI, LO loads and the registered completion pulse
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_y    <= '0;
            r_z    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            if (r_state == S_Y) r_y <= w_bus;
            if (r_state == S_Z) r_z <= w_alu;
            if ((r_state == S_WB) && (r_op == OP_MUL)) r_lo <= w_bus;
            if (r_state == S_HI) r_hi <= w_bus;
            r_done <= w_wb_reg || (r_state == S_HI);
        end
    end

    // Register file: external write only in IDLE, writeback only in S_WB
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if ((r_state == IDLE) && wr_en) begin
            r_regs[wr_addr] <= wr_data;
        end else if (w_wb_reg) begin
            r_regs[r_rc] <= w_bus;
        end
    end

    assign ready   = (r_state == IDLE);
    assign done    = r_done;
    assign rd_data = r_regs[rd_addr];
    assign hi_q    = r_hi;
    assign lo_q    = r_lo;
    assign bus_q   = w_bus;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: 32-bit/16-reg instance plus an
// 8-bit/4-reg instance for the narrow-width corners.
module tb_bus_datapath_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  op;
    logic [3:0]  ra, rb, rc, wr_addr, rd_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        ready, done;
    logic [31:0] rd_data, hi_q, lo_q, bus_q;

    logic        start8;
    logic [2:0]  op8;
    logic [1:0]  ra8, rb8, rc8, wr_addr8, rd_addr8;
    logic        wr_en8;
    logic [7:0]  wr_data8;
    logic        ready8, done8;
    logic [7:0]  rd_data8, hi_q8, lo_q8, bus_q8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .ready(ready), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .hi_q(hi_q), .lo_q(lo_q), .bus_q(bus_q)
    );

    bus_datapath_seq #(.DATA_W(8), .NUM_REGS(4)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .op(op8), .ra(ra8), .rb(rb8), .rc(rc8),
        .ready(ready8), .done(done8), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .rd_addr(rd_addr8), .rd_data(rd_data8), .hi_q(hi_q8), .lo_q(lo_q8), .bus_q(bus_q8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  ra, rb, rc;
        logic [31:0] a, b;
        logic [31:0] exp_rc, exp_lo, exp_hi;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, output int lat);
        start = 1'b1; op = o; ra = a; rb = b; rc = c;
        tick();
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic write8(input logic [1:0] a, input logic [7:0] d);
        wr_en8 = 1'b1; wr_addr8 = a; wr_data8 = d;
        tick();
        wr_en8 = 1'b0;
    endtask

    task automatic run8(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, output int lat);
        start8 = 1'b1; op8 = o; ra8 = a; rb8 = b; rc8 = c;
        tick();
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (done8) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        logic        seen;

        vecs[0]  = '{3'b000, 4'd3, 4'd4, 4'd5,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 3};
        vecs[1]  = '{3'b110, 4'd1, 4'd2, 4'd6,  32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0000, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 4};
        vecs[2]  = '{3'b000, 4'd1, 4'd2, 4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 3};
        vecs[3]  = '{3'b001, 4'd2, 4'd1, 4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 3};
        vecs[4]  = '{3'b100, 4'd1, 4'd8, 4'd10, 32'hFFFF_FFFF, 32'd33,        32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 3};
        vecs[5]  = '{3'b101, 4'd1, 4'd8, 4'd11, 32'hFFFF_FFFF, 32'd33,        32'h7FFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 3};
        vecs[6]  = '{3'b010, 4'd3, 4'd4, 4'd12, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 3};
        vecs[7]  = '{3'b011, 4'd3, 4'd4, 4'd13, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 3};
        vecs[8]  = '{3'b111, 4'd3, 4'd4, 4'd14, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 3};
        vecs[9]  = '{3'b110, 4'd3, 4'd4, 4'd15, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 32'h0000_0000, 4};
        vecs[10] = '{3'b000, 4'd3, 4'd3, 4'd3,  32'h0000_0011, 32'h0000_0011, 32'h0000_0022, 32'h0000_002A, 32'h0000_0000, 3};

        clr = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        start8 = 1'b0; op8 = '0; ra8 = '0; rb8 = '0; rc8 = '0;
        wr_en8 = 1'b0; wr_addr8 = '0; wr_data8 = '0; rd_addr8 = '0;
        tick(); tick();
        clr = 1'b1;
        tick();

        // Dirty some registers, then reset while idle
        write_reg(4'd0, 32'hAAAA_5555);
        write_reg(4'd15, 32'h1234_5678);
        clr = 1'b0;
        #2;
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_bus", bus_q, 32'h0);
        check("rst_hi", hi_q, 32'h0);
        check("rst_lo", lo_q, 32'h0);
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), d);
            check($sformatf("rst_r%0d", i), d, 32'h0);
        end
        clr = 1'b1;
        tick();

        // Table of single operations
        for (int i = 0; i < 11; i++) begin
            write_reg(vecs[i].ra, vecs[i].a);
            write_reg(vecs[i].rb, vecs[i].b);
            check($sformatf("v%0d_ready", i), ready, 1'b1);
            run_op(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            tick();
            check($sformatf("v%0d_done_pulse", i), done, 1'b0);
            read_reg(vecs[i].rc, d);
            check($sformatf("v%0d_rc", i), d, vecs[i].exp_rc);
            check($sformatf("v%0d_lo", i), lo_q, vecs[i].exp_lo);
            check($sformatf("v%0d_hi", i), hi_q, vecs[i].exp_hi);
        end

        // Back-to-back handshake with start held high
        write_reg(4'd1, 32'd5);
        write_reg(4'd2, 32'd7);
        write_reg(4'd9, 32'h99);
        start = 1'b1; op = 3'b000; ra = 4'd1; rb = 4'd2; rc = 4'd6;
        tick();
        check("hs_sy_ready", ready, 1'b0);
        check("hs_sy_bus", bus_q, 32'd5);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hDEAD;
        tick();
        check("hs_sz_ready", ready, 1'b0);
        check("hs_sz_bus", bus_q, 32'd7);
        tick();
        check("hs_swb_ready", ready, 1'b0);
        check("hs_swb_bus", bus_q, 32'd12);
        wr_en = 1'b0;
        tick();
        check("hs_done1", done, 1'b1);
        check("hs_done1_ready", ready, 1'b1);
        tick();
        check("hs_accept2_ready", ready, 1'b0);
        check("hs_accept2_done", done, 1'b0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("hs_done2", done, 1'b1);
        tick();
        check("hs_no_queue_ready", ready, 1'b1);
        check("hs_no_queue_done", done, 1'b0);
        read_reg(4'd9, d);
        check("hs_r9_kept", d, 32'h99);
        read_reg(4'd6, d);
        check("hs_r6", d, 32'd12);

        // Simultaneous external write and start
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h10;
        run_op(3'b000, 4'd1, 4'd1, 4'd1, lat);
        wr_en = 1'b0;
        check("sim_latency", lat, 3);
        tick();
        read_reg(4'd1, d);
        check("sim_r1", d, 32'h20);

        // Reset during S_Z aborts with no writeback
        start = 1'b1; op = 3'b000; ra = 4'd1; rb = 4'd1; rc = 4'd1;
        tick();
        start = 1'b0;
        tick();
        clr = 1'b0;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_bus", bus_q, 32'h0);
        check("abort_done", done, 1'b0);
        #1;
        clr = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        read_reg(4'd1, d);
        check("abort_r1", d, 32'h0);

        // Narrow instance: signed MUL and 3-bit shift amount
        write8(2'd1, 8'h80);
        write8(2'd2, 8'h02);
        run8(3'b110, 2'd1, 2'd2, 2'd3, lat);
        check("n8_mul_latency", lat, 4);
        check("n8_mul_lo", lo_q8, 8'h00);
        check("n8_mul_hi", hi_q8, 8'hFF);
        rd_addr8 = 2'd3;
        #1;
        check("n8_mul_rc", rd_data8, 8'h00);
        tick();
        write8(2'd0, 8'h03);
        write8(2'd2, 8'h09);
        run8(3'b100, 2'd0, 2'd2, 2'd3, lat);
        check("n8_shl_latency", lat, 3);
        tick();
        rd_addr8 = 2'd3;
        #1;
        check("n8_shl_r3", rd_data8, 8'h06);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
- Parametrised single-bus datapath with its own operation sequencer. It holds a NUM_REGS x DATA_W register file, plus Y, a 2*DATA_W Z (ZHI/ZLO), HI and LO.
- One internal bus is driven by exactly one one-hot-selected source per cycle.
- A start/done handshake runs a register-to-register ALU operation as a fixed T-state sequence: Y <- Ra; Z <- Y op Rb; Rc/LO <- ZLO; HI <- ZHI.
- Sits between the control unit and the memory/I-O interface. It replaces hand-driven rX_in strobes with sequenced transfers.

Parameters:
- DATA_W, 32, width of the bus and of every register; Z is 2*DATA_W.
- NUM_REGS, 16, general registers; must be a power of two and at least 2.
- REG_AW, $clog2(NUM_REGS), register address width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-low reset.
- start  in  1  request an operation; accepted only when ready=1.
- op  in  3  operation code, sampled with start.
- ra, rb, rc  in  REG_AW each  source A, source B and destination addresses, sampled with start.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse on completion.
- wr_en  in  1  external register write; honoured only in IDLE.
- wr_addr  in  REG_AW  external write address.
- wr_data  in  DATA_W  external write data.
- rd_addr  in  REG_AW  read address.
- rd_data  out  DATA_W  combinational R[rd_addr].
- hi_q, lo_q  out  DATA_W  HI and LO register contents.
- bus_q  out  DATA_W  current internal bus value (debug).

Behaviour:
- Reset (clr=0, async):
  - All registers, Y, Z, HI and LO clear to 0.
  - State goes to IDLE; ready=1, done=0, bus_q=0.
  - Reset mid-sequence aborts the operation with no writeback.
- States: IDLE, S_Y, S_Z, S_WB, S_HI.
  - IDLE: bus source none (bus=0). If start=1, latch op/ra/rb/rc and go to S_Y.
  - S_Y: bus=R[ra]; Y <= bus; go to S_Z.
  - S_Z: bus=R[rb]; Z <= ALU(Y, bus); go to S_WB.
  - S_WB: bus=ZLO. For MUL, LO <= bus and go to S_HI. Otherwise R[rc] <= bus and go to IDLE.
  - S_HI: bus=ZHI; HI <= bus; go to IDLE.
- Bus source select is one-hot, generated from state only. Zero or one source is active; never two.
- done is registered. It is high for exactly the one cycle after the final write edge, coinciding with the return to IDLE and ready=1.
- Latency from the start-accept edge to done=1: 3 cycles for non-MUL ops, 4 cycles for MUL.
- A new start may be accepted in the same cycle done=1, because that cycle is IDLE.
- start while not ready is ignored and not queued. op/ra/rb/rc changes while busy have no effect.
- ALU (ZHI=0 unless stated; shift amount = bus[$clog2(DATA_W)-1:0]):
  - 000 ADD: ZLO = Y+B mod 2^DATA_W.
  - 001 SUB: ZLO = Y-B mod 2^DATA_W.
  - 010 AND.
  - 011 OR.
  - 100 SHL: logical.
  - 101 SHR: logical, zero fill.
  - 110 MUL: signed; Z = full 2*DATA_W two's-complement product.
  - 111 XOR.
- External write:
  - wr_en in IDLE writes R[wr_addr] <= wr_data at the edge.
  - If start and wr_en are both high in IDLE, both are honoured. The write lands first, so S_Y/S_Z see the new value.
  - wr_en outside IDLE is dropped.
- ra=rb and rc equal to ra or rb are legal. Operands are read before writeback.
- rd_data reflects a write on the cycle after the write edge.

Test Plan:
- Reset then load: pulse clr low mid-idle → every rd_data, hi_q and lo_q read 0. Write R3=0x0000_0005 and R4=0x0000_0003; start op=000, ra=3, rb=4, rc=5 → done exactly 3 cycles after accept, R5=0x0000_0008, HI/LO unchanged.
- MUL signed: R1=0xFFFF_FFFE (-2), R2=0x0000_0003; op=110, ra=1, rb=2 → done at 4 cycles; LO=0xFFFF_FFFA, HI=0xFFFF_FFFF; R[rc] unchanged.
- Wrap and shift: R1=0xFFFF_FFFF, R2=1.
  - ADD into R6 → 0.
  - SUB R2-R1 into R7 → 2.
  - SHL R1 by R8=33 (amount 1) → 0xFFFF_FFFE.
  - SHR by R8 → 0x7FFF_FFFF.
- Handshake: hold start high continuously for ops on R1/R2 → back-to-back accepts every 4 cycles (done cycle = next accept). ready=0 in S_Y..S_WB; start pulses while busy are ignored; wr_en to R9 while busy leaves R9 unchanged.
- Simultaneous wr_en+start in IDLE: wr R1=0x10, start ADD ra=1, rb=1, rc=1 → R1=0x20. Then assert clr low during S_Z of a second ADD → no writeback, R1=0 after reset, done never pulses.
- Parameter sweep: DATA_W=8, NUM_REGS=4 → MUL 0x80*0x02: LO=0x00, HI=0xFF. SHL amount uses 3 bits.
